// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture stage: FSM states,
// default frame geometry, buffer address width and the luma helper.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SYNC,
    CAPTURE
  } cap_state_t;

  localparam int ADDR_W       = 15;
  localparam int DEF_H_PIXELS = 160;
  localparam int DEF_V_LINES  = 120;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  // RGB565 -> 8-bit luma; weights sum to 256 so the 16-bit sum cannot overflow
  function automatic logic [7:0] rgb565_to_y(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {hi[7:3], hi[7:5]};
    g8  = {hi[2:0], lo[7:5], hi[2:1]};
    b8  = {lo[4:0], lo[4:2]};
    sum = 16'(LUMA_R) * {8'd0, r8} + 16'(LUMA_G) * {8'd0, g8} + 16'(LUMA_B) * {8'd0, b8};
    return sum[15:8];
  endfunction

endpackage

// File: rtl/cam_bus_sync.sv
// Brings the camera bus into the i_clk domain through one shared 2-flop chain
// and derives pclk rising-edge events plus vsync/href edge strobes.
module cam_bus_sync (
  input  logic       i_clk,
  input  logic       i_Reset_n,
  input  logic       i_Cam_Pclk,
  input  logic       i_Cam_Vsync,
  input  logic       i_Cam_Href,
  input  logic [7:0] i_Cam_Data,
  output logic       pclk_event,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href,
  output logic       href_fall,
  output logic [7:0] data
);

  localparam int BUS_W = 11;

  logic [BUS_W-1:0] bus_in;
  logic [BUS_W-1:0] sync1_reg;
  logic [BUS_W-1:0] sync2_reg;
  logic             pclk_prev_reg;
  logic             vsync_prev_reg;
  logic             href_prev_reg;

  assign bus_in = {i_Cam_Pclk, i_Cam_Vsync, i_Cam_Href, i_Cam_Data};

  // Every bit sees the same two stages, so data stays aligned with pclk/href
  genvar gi;
  generate
    for (gi = 0; gi < BUS_W; gi++) begin : g_sync
      always_ff @(posedge i_clk) begin
        if (!i_Reset_n) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= bus_in[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_Reset_n) begin
      pclk_prev_reg  <= 1'b0;
      vsync_prev_reg <= 1'b0;
      href_prev_reg  <= 1'b0;
    end else begin
      pclk_prev_reg  <= sync2_reg[10];
      vsync_prev_reg <= sync2_reg[9];
      href_prev_reg  <= sync2_reg[8];
    end
  end

  assign pclk_event = sync2_reg[10] & ~pclk_prev_reg;
  assign vsync_rise = sync2_reg[9] & ~vsync_prev_reg;
  assign vsync_fall = ~sync2_reg[9] & vsync_prev_reg;
  assign href       = sync2_reg[8];
  assign href_fall  = ~sync2_reg[8] & href_prev_reg;
  assign data       = sync2_reg[7:0];

endmodule

// File: rtl/cam_capture_rgb.sv
// Camera capture: packs RGB565 byte pairs into 8-bit pixels and writes one
// frame into the frame buffer. Define GRAYSCALE_EN for luma output (+1 cycle).
module cam_capture_rgb
  import cam_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES
) (
  input  logic              i_clk,
  input  logic              i_Reset_n,
  input  logic              i_Start,
  input  logic              i_Continuous,
  input  logic              i_Cam_Pclk,
  input  logic              i_Cam_Vsync,
  input  logic              i_Cam_Href,
  input  logic [7:0]        i_Cam_Data,
  output logic [7:0]        o_Data,
  output logic [ADDR_W-1:0] o_Write_Adress,
  output logic              o_Enable_Write,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic              o_Frame_Error
);

  localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam int COL_W        = $clog2(H_PIXELS + 1);
  localparam int ROW_W        = $clog2(V_LINES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  logic       pclk_event;
  logic       vsync_rise;
  logic       vsync_fall;
  logic       cam_href;
  logic       href_fall;
  logic [7:0] cam_data;

  cam_bus_sync u_sync (
    .i_clk      (i_clk),
    .i_Reset_n  (i_Reset_n),
    .i_Cam_Pclk (i_Cam_Pclk),
    .i_Cam_Vsync(i_Cam_Vsync),
    .i_Cam_Href (i_Cam_Href),
    .i_Cam_Data (i_Cam_Data),
    .pclk_event (pclk_event),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href       (cam_href),
    .href_fall  (href_fall),
    .data       (cam_data)
  );

  cap_state_t        state_reg, state_next;
  logic              accept_start;
  logic              start_frame;
  logic              end_frame;

  logic              phase_reg;
  logic [7:0]        hi_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              full_reg;
  logic              overflow_reg;
  logic              wr_en_reg;
  logic [7:0]        data_reg;
  logic              done_reg;
  logic              err_reg;

  logic              capturing;
  logic              byte_event;
  logic              pixel_event;
  logic              in_window;
  logic              write_req;
  logic              frame_short;
  logic              stage_valid;
  logic [7:0]        stage_pixel;

  always_ff @(posedge i_clk) begin
    if (!i_Reset_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    accept_start = 1'b0;
    start_frame  = 1'b0;
    end_frame    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_Start) begin
          accept_start = 1'b1;
          state_next   = ARM;
        end
      end
      ARM: begin
        if (vsync_rise) state_next = SYNC;
      end
      SYNC: begin
        if (vsync_fall) begin
          start_frame = 1'b1;
          state_next  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          end_frame  = 1'b1;
          state_next = i_Continuous ? SYNC : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign capturing   = (state_reg == CAPTURE);
  assign byte_event  = capturing && pclk_event && cam_href;
  assign pixel_event = byte_event && phase_reg;
  assign in_window   = (col_reg < COL_W'(H_PIXELS)) && (row_reg < ROW_W'(V_LINES));
  assign write_req   = pixel_event && in_window && !full_reg;

  // Byte phase and line/row position; a dangling odd byte dies with href
  always_ff @(posedge i_clk) begin
    if (!i_Reset_n) begin
      phase_reg <= 1'b0;
      hi_reg    <= 8'd0;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      if (!cam_href)       phase_reg <= 1'b0;
      else if (byte_event) phase_reg <= ~phase_reg;

      if (byte_event && !phase_reg) hi_reg <= cam_data;

      if (start_frame) begin
        col_reg <= '0;
        row_reg <= '0;
      end else if (capturing && href_fall) begin
        col_reg <= '0;
        if (row_reg < ROW_W'(V_LINES)) row_reg <= row_reg + 1'b1;
      end else if (pixel_event && (col_reg < COL_W'(H_PIXELS))) begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

`ifdef GRAYSCALE_EN
  logic       pend_reg;
  logic [7:0] pend_hi_reg;
  logic [7:0] pend_lo_reg;

  always_ff @(posedge i_clk) begin
    if (!i_Reset_n) begin
      pend_reg    <= 1'b0;
      pend_hi_reg <= 8'd0;
      pend_lo_reg <= 8'd0;
    end else begin
      pend_reg <= write_req;
      if (write_req) begin
        pend_hi_reg <= hi_reg;
        pend_lo_reg <= cam_data;
      end
    end
  end

  assign stage_valid = pend_reg;
  assign stage_pixel = rgb565_to_y(pend_hi_reg, pend_lo_reg);
`else
  logic unused_color_bits;

  assign stage_valid       = write_req;
  assign stage_pixel       = {hi_reg[7:5], hi_reg[2:0], cam_data[4:3]};
  assign unused_color_bits = ^{hi_reg[4:3], cam_data[7:5], cam_data[2:0]};
`endif

  // A strobe still in flight on the closing edge counts toward the frame
  assign frame_short = !(full_reg || (wr_en_reg && (addr_reg == LAST_ADDR)));

  always_ff @(posedge i_clk) begin
    if (!i_Reset_n) begin
      wr_en_reg    <= 1'b0;
      data_reg     <= 8'd0;
      addr_reg     <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      wr_en_reg <= stage_valid;
      if (stage_valid) data_reg <= stage_pixel;

      if (start_frame) begin
        addr_reg     <= '0;
        full_reg     <= 1'b0;
        overflow_reg <= 1'b0;
      end else begin
        if (wr_en_reg) begin
          if (addr_reg == LAST_ADDR) full_reg <= 1'b1;
          else                       addr_reg <= addr_reg + 1'b1;
        end
        if (pixel_event && in_window && full_reg) overflow_reg <= 1'b1;
      end

      done_reg <= end_frame;
      if (accept_start)   err_reg <= 1'b0;
      else if (end_frame) err_reg <= frame_short || overflow_reg;
    end
  end

  assign o_Data         = data_reg;
  assign o_Write_Adress = addr_reg;
  assign o_Enable_Write = wr_en_reg;
  assign o_Busy         = (state_reg != IDLE);
  assign o_Frame_Done   = done_reg;
  assign o_Frame_Error  = err_reg;

endmodule
